// File: rtl/maq_timer.sv
// maq_timer: MM:SS BCD countdown timer with an IDLE/RUN/PAUSE/DONE state machine.
//
// Ports
//   maqt_clock          in   sole clock, rising edge
//   maqt_reset          in   asynchronous, active-low reset
//   maqt_tick           in   1 Hz enable pulse, one clock wide; decrements the count in RUN
//   maqt_load           in   strobe; loads the (clamped) preset digits and returns to IDLE
//   maqt_start          in   strobe; starts or resumes a non-zero count
//   maqt_pause          in   strobe; freezes a running count
//   maqt_pre_min_msd    in   [2:0] preset minutes tens digit (values above 5 clamp to 5)
//   maqt_pre_min_lsd    in   [3:0] preset minutes units digit (values above 9 clamp to 9)
//   maqt_pre_sec_msd    in   [2:0] preset seconds tens digit (values above 5 clamp to 5)
//   maqt_pre_sec_lsd    in   [3:0] preset seconds units digit (values above 9 clamp to 9)
//   maqt_min_msd/lsd    out  registered minutes digits
//   maqt_sec_msd/lsd    out  registered seconds digits
//   maqt_running        out  high while in RUN
//   maqt_done           out  high while in DONE
//   maqt_alarm          out  one-clock pulse when the count reaches 00:00
module maq_timer (
  input  logic       maqt_clock,
  input  logic       maqt_reset,
  input  logic       maqt_tick,
  input  logic       maqt_load,
  input  logic       maqt_start,
  input  logic       maqt_pause,
  input  logic [2:0] maqt_pre_min_msd,
  input  logic [3:0] maqt_pre_min_lsd,
  input  logic [2:0] maqt_pre_sec_msd,
  input  logic [3:0] maqt_pre_sec_lsd,
  output logic [2:0] maqt_min_msd,
  output logic [3:0] maqt_min_lsd,
  output logic [2:0] maqt_sec_msd,
  output logic [3:0] maqt_sec_lsd,
  output logic       maqt_running,
  output logic       maqt_done,
  output logic       maqt_alarm
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t state;

  // Tens digits saturate at 5 so a bad preset can never show e.g. 7x:xx.
  function automatic logic [2:0] clamp_msd(input logic [2:0] d);
    return (d > 3'd5) ? 3'd5 : d;
  endfunction

  // Units digits saturate at 9 so a bad preset can never show a non-BCD code.
  function automatic logic [3:0] clamp_lsd(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  // One-second BCD decrement of {min_msd, min_lsd, sec_msd, sec_lsd} with
  // borrow rippling from seconds units up to minutes tens. Only applied to a
  // non-zero count, so the minutes tens digit never has to wrap.
  function automatic logic [13:0] dec_count(input logic [13:0] c);
    logic [2:0] mm;
    logic [3:0] ml;
    logic [2:0] sm;
    logic [3:0] sl;
    {mm, ml, sm, sl} = c;
    if (sl != 4'd0) begin
      sl = sl - 4'd1;
    end else begin
      sl = 4'd9;
      if (sm != 3'd0) begin
        sm = sm - 3'd1;
      end else begin
        sm = 3'd5;
        if (ml != 4'd0) begin
          ml = ml - 4'd1;
        end else begin
          ml = 4'd9;
          if (mm != 3'd0) mm = mm - 3'd1;
        end
      end
    end
    return {mm, ml, sm, sl};
  endfunction

  logic [13:0] count_now;
  logic [13:0] count_dec;
  logic        count_zero;
  logic        dec_zero;

  assign count_now  = {maqt_min_msd, maqt_min_lsd, maqt_sec_msd, maqt_sec_lsd};
  assign count_dec  = dec_count(count_now);
  assign count_zero = (count_now == 14'd0);
  assign dec_zero   = (count_dec == 14'd0);

  // Registered state, count and flags; strobe priority is load > pause > start > tick.
  always_ff @(posedge maqt_clock or negedge maqt_reset) begin
    if (!maqt_reset) begin
      state        <= IDLE;
      maqt_min_msd <= 3'd0;
      maqt_min_lsd <= 4'd0;
      maqt_sec_msd <= 3'd0;
      maqt_sec_lsd <= 4'd0;
      maqt_running <= 1'b0;
      maqt_done    <= 1'b0;
      maqt_alarm   <= 1'b0;
    end else begin
      maqt_alarm <= 1'b0;
      if (maqt_load) begin
        state        <= IDLE;
        maqt_min_msd <= clamp_msd(maqt_pre_min_msd);
        maqt_min_lsd <= clamp_lsd(maqt_pre_min_lsd);
        maqt_sec_msd <= clamp_msd(maqt_pre_sec_msd);
        maqt_sec_lsd <= clamp_lsd(maqt_pre_sec_lsd);
        maqt_running <= 1'b0;
        maqt_done    <= 1'b0;
      end else if (maqt_pause) begin
        if (state == RUN) begin
          state        <= PAUSE;
          maqt_running <= 1'b0;
        end
      end else if (maqt_start) begin
        if ((state == IDLE || state == PAUSE) && !count_zero) begin
          state        <= RUN;
          maqt_running <= 1'b1;
        end
      end else if (maqt_tick && state == RUN) begin
        {maqt_min_msd, maqt_min_lsd, maqt_sec_msd, maqt_sec_lsd} <= count_dec;
        // Reaching 00:00 finishes on this same edge.
        if (dec_zero) begin
          state        <= DONE;
          maqt_running <= 1'b0;
          maqt_done    <= 1'b1;
          maqt_alarm   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/maq_timer.md
MAQ_TIMER -- requirements
Module: maq_timer

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 maqt_clock  input  1  sole clock; all state changes on its rising edge.
REQ-003 maqt_reset  input  1  reset, asynchronous, active-low.
REQ-004 maqt_tick  input  1  1 Hz enable pulse, one clock wide; decrement qualifier.
REQ-005 maqt_load  input  1  one-cycle strobe; copies the preset inputs into the count.
REQ-006 maqt_start  input  1  one-cycle strobe; starts or resumes the countdown.
REQ-007 maqt_pause  input  1  one-cycle strobe; freezes the countdown.
REQ-008 maqt_pre_min_msd  input  3  preset minutes tens digit, BCD 0-5.
REQ-009 maqt_pre_min_lsd  input  4  preset minutes units digit, BCD 0-9.
REQ-010 maqt_pre_sec_msd  input  3  preset seconds tens digit, BCD 0-5.
REQ-011 maqt_pre_sec_lsd  input  4  preset seconds units digit, BCD 0-9.
REQ-012 maqt_min_msd / maqt_min_lsd / maqt_sec_msd / maqt_sec_lsd  output  3/4/3/4  registered count digits, MM:SS BCD.
REQ-013 maqt_running  output  1  high while the FSM is in RUN.
REQ-014 maqt_done  output  1  high while the FSM is in DONE.
REQ-015 maqt_alarm  output  1  one-clock pulse when the count reaches 00:00.

Function
REQ-016 FSM states SHALL be IDLE, RUN, PAUSE and DONE; all outputs SHALL be registered.
REQ-017 Input priority each cycle SHALL be load > pause > start > tick.
REQ-018 load in any state SHALL copy the preset into the count, enter IDLE, and clear maqt_alarm.
REQ-019 A preset digit out of range SHALL be clamped: lsd > 9 becomes 9, msd > 5 becomes 5.
REQ-020 start in IDLE or PAUSE with count != 00:00 SHALL enter RUN on the next edge.
REQ-021 start with count == 00:00, or in DONE, SHALL be ignored.
REQ-022 pause in RUN SHALL enter PAUSE with the count frozen.
REQ-023 pause in any other state SHALL be ignored.
REQ-024 tick SHALL decrement the count only in RUN, and only when load, pause and start are all low in that cycle.
REQ-025 tick in IDLE, PAUSE or DONE SHALL have no effect.
REQ-026 Decrement rule: sec_lsd SHALL count down; at 0 it SHALL wrap to 9 and borrow from sec_msd.
REQ-027 sec_msd SHALL wrap 0 to 5 and borrow from min_lsd.
REQ-028 min_lsd SHALL wrap 0 to 9 and borrow from min_msd.
REQ-029 min_msd SHALL decrement only on borrow and never wrap.
REQ-030 When a decrement produces 00:00, the same edge SHALL enter DONE and assert maqt_alarm for exactly one cycle.
REQ-031 DONE SHALL hold 00:00 and maqt_done high until load or reset.
REQ-032 Latency: the count digits SHALL update on the edge sampling tick; running/done SHALL update on the edge of the state transition.
REQ-033 No digit SHALL ever show a non-BCD value, or a tens digit > 5.

Reset
REQ-034 On maqt_reset low, asynchronously: state IDLE; all digits 0; maqt_running, maqt_done and maqt_alarm 0.
REQ-035 Reset asserted mid-count SHALL abort the countdown with no alarm pulse.
REQ-036 After reset release the block SHALL wait for load; start with the zero count SHALL be ignored.

Verification
REQ-037 Load preset 01:00, start, one tick -> count 00:59; running=1.
REQ-038 Load 00:02, start, two ticks -> 00:01, then 00:00; on the second tick edge done=1 and alarm high one cycle only; further ticks keep 00:00.
REQ-039 Load 10:00, start, one tick -> 09:59 (borrow through all four digits).
REQ-040 In RUN with count 00:30, pause and tick in the same cycle -> PAUSE, count stays 00:30; start -> RUN; next tick -> 00:29.
REQ-041 Load preset min_msd=7, sec_lsd=12 (other digits 0) -> count 50:09; load together with start -> IDLE, count 50:09, running=0.
REQ-042 Reset pulse while in RUN at 03:15 -> all digits 0, state IDLE, no alarm; start without load -> stays IDLE.
